// File: rtl/spi_shift_register_if.sv
// ----------------------------------------------------------------------------
// spi_shift_register_if
// Bundles the control, strobe and data signals of the SPI master datapath
// shift register.
//   master : control FSM / baud generator side; drives ss, send_data, lsbfe,
//            cpha, cpol, the four strobes, data_mosi, miso and receive_data.
//            Observes mosi and data_miso.
//   slave  : the shift register itself.
// ----------------------------------------------------------------------------
interface spi_shift_register_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  ss;
    logic                  send_data;
    logic                  lsbfe;
    logic                  cpha;
    logic                  cpol;
    logic                  flag_low;
    logic                  flag_high;
    logic                  flags_low;
    logic                  flags_high;
    logic [DATA_WIDTH-1:0] data_mosi;
    logic                  miso;
    logic                  receive_data;
    logic                  mosi;
    logic [DATA_WIDTH-1:0] data_miso;

    modport master (
        output ss, send_data, lsbfe, cpha, cpol,
        output flag_low, flag_high, flags_low, flags_high,
        output data_mosi, miso, receive_data,
        input  mosi, data_miso
    );

    modport slave (
        input  ss, send_data, lsbfe, cpha, cpol,
        input  flag_low, flag_high, flags_low, flags_high,
        input  data_mosi, miso, receive_data,
        output mosi, data_miso
    );
endinterface

// File: rtl/spi_shift_register.sv
// ----------------------------------------------------------------------------
// spi_shift_register
// Datapath shift register of the SPI master. Loads a parallel byte and shifts
// it out on mosi on TX strobes; samples miso on RX strobes into a receive
// register that is copied to data_miso while receive_data is high.
//
// Ports:
//   PCLK    : system clock, rising edge
//   PRESET  : synchronous active-high reset
//   bus     : spi_shift_register_if.slave (control, strobes, data, mosi/miso)
//
// Optional build macro:
//   SPI_LOOPBACK_EN : receive path samples the value being driven on mosi
//                     instead of the miso pin.
// ----------------------------------------------------------------------------
module spi_shift_register #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    spi_shift_register_if.slave     bus
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_WIDTH-1:0] tx_reg_r;
    logic [DATA_WIDTH-1:0] rx_reg_r;
    logic [CNT_W-1:0]      tx_cnt_r;
    logic [CNT_W-1:0]      rx_cnt_r;
    logic                  mosi_r;
    logic [DATA_WIDTH-1:0] data_miso_r;

    logic                  sel_s;
    logic                  tx_strobe_s;
    logic                  rx_strobe_s;
    logic                  tx_shift_s;
    logic                  rx_shift_s;
    logic [CNT_W-1:0]      tx_idx_s;
    logic [CNT_W-1:0]      rx_idx_s;
    logic [CNT_W-1:0]      tx_cnt_next_s;
    logic [CNT_W-1:0]      rx_cnt_next_s;
    logic                  mosi_next_s;
    logic                  rx_bit_s;

    // Bit position for a frame counter under the current bit order.
    function automatic logic [CNT_W-1:0] bit_index(input logic lsb_first,
                                                   input logic [CNT_W-1:0] cnt);
        if (lsb_first) begin
            return cnt;
        end else begin
            return CNT_MAX - cnt;
        end
    endfunction

    // Wrapping frame counter increment.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == CNT_MAX) begin
            return CNT_ZERO;
        end else begin
            return cnt + CNT_ONE;
        end
    endfunction

    // Strobe selection, bit indices and the value mosi takes this edge.
    always_comb begin
        sel_s         = bus.cpha ^ bus.cpol;
        tx_strobe_s   = sel_s ? bus.flag_high  : bus.flag_low;
        rx_strobe_s   = sel_s ? bus.flags_high : bus.flags_low;
        // A load on the same edge swallows the TX strobe.
        tx_shift_s    = tx_strobe_s & ~bus.ss & ~bus.send_data;
        rx_shift_s    = rx_strobe_s & ~bus.ss;
        tx_idx_s      = bit_index(bus.lsbfe, tx_cnt_r);
        rx_idx_s      = bit_index(bus.lsbfe, rx_cnt_r);
        tx_cnt_next_s = cnt_inc(tx_cnt_r);
        rx_cnt_next_s = cnt_inc(rx_cnt_r);
        if (tx_shift_s) begin
            mosi_next_s = tx_reg_r[tx_idx_s];
        end else begin
            mosi_next_s = mosi_r;
        end
`ifdef SPI_LOOPBACK_EN
        // Sample the bit being launched so coincident TX/RX strobes loop
        // the frame back intact.
        rx_bit_s      = mosi_next_s;
`else
        rx_bit_s      = bus.miso;
`endif
    end

    // Transmit register, transmit counter and mosi output register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_reg_r <= {DATA_WIDTH{1'b0}};
            tx_cnt_r <= CNT_ZERO;
            mosi_r   <= 1'b0;
        end else if (bus.send_data) begin
            tx_reg_r <= bus.data_mosi;
            tx_cnt_r <= CNT_ZERO;
        end else if (bus.ss) begin
            tx_cnt_r <= CNT_ZERO;
        end else if (tx_shift_s) begin
            mosi_r   <= mosi_next_s;
            tx_cnt_r <= tx_cnt_next_s;
        end else begin
            tx_cnt_r <= tx_cnt_r;
        end
    end

    // Receive register and receive counter.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_reg_r <= {DATA_WIDTH{1'b0}};
            rx_cnt_r <= CNT_ZERO;
        end else if (bus.ss) begin
            rx_cnt_r <= CNT_ZERO;
        end else if (rx_shift_s) begin
            rx_reg_r[rx_idx_s] <= rx_bit_s;
            rx_cnt_r           <= rx_cnt_next_s;
        end else begin
            rx_cnt_r <= rx_cnt_r;
        end
    end

    // Parallel receive output, refreshed while receive_data is high.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            data_miso_r <= {DATA_WIDTH{1'b0}};
        end else if (bus.receive_data) begin
            data_miso_r <= rx_reg_r;
        end else begin
            data_miso_r <= data_miso_r;
        end
    end

    assign bus.mosi      = mosi_r;
    assign bus.data_miso = data_miso_r;

endmodule

// File: tb/tb_spi_shift_register.sv
// ----------------------------------------------------------------------------
// tb_spi_shift_register
// Directed bench for spi_shift_register with hand-computed expected values.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_spi_shift_register;
    logic PCLK;
    logic PRESET;
    int   n_checks;
    int   n_pass;
    logic exp_mosi;

    spi_shift_register_if #(.DATA_WIDTH(8)) bus ();

    spi_shift_register #(.DATA_WIDTH(8)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus.slave)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One-cycle pulse on the selected strobes with miso driven to m.
    task automatic strobe(input logic fl, input logic fh, input logic sl,
                          input logic sh, input logic m);
        bus.flag_low   = fl;
        bus.flag_high  = fh;
        bus.flags_low  = sl;
        bus.flags_high = sh;
        bus.miso       = m;
        tick();
        bus.flag_low   = 1'b0;
        bus.flag_high  = 1'b0;
        bus.flags_low  = 1'b0;
        bus.flags_high = 1'b0;
    endtask

    task automatic load(input logic [7:0] d);
        bus.data_mosi = d;
        bus.send_data = 1'b1;
        tick();
        bus.send_data = 1'b0;
    endtask

    initial begin
        logic [7:0] miso_pat;
        logic [7:0] mosi_exp;
        n_checks = 0;
        n_pass   = 0;
        bus.ss = 1'b1; bus.send_data = 1'b0; bus.lsbfe = 1'b1;
        bus.cpha = 1'b0; bus.cpol = 1'b0;
        bus.flag_low = 1'b0; bus.flag_high = 1'b0;
        bus.flags_low = 1'b0; bus.flags_high = 1'b0;
        bus.data_mosi = 8'h00; bus.miso = 1'b0; bus.receive_data = 1'b0;

        // Reset with strobes active and ss low.
        PRESET = 1'b1;
        bus.ss = 1'b0; bus.receive_data = 1'b1;
        bus.flag_low = 1'b1; bus.flags_low = 1'b1; bus.miso = 1'b1;
        tick();
        tick();
        check_eq("reset_mosi", {31'd0, bus.mosi}, 32'd0);
        check_eq("reset_data_miso", {24'd0, bus.data_miso}, 32'h00);
        bus.flag_low = 1'b0; bus.flags_low = 1'b0; bus.miso = 1'b0;
        PRESET = 1'b0;
        tick();
        tick();
        check_eq("post_reset_mosi", {31'd0, bus.mosi}, 32'd0);
        check_eq("post_reset_data_miso", {24'd0, bus.data_miso}, 32'h00);

        // Mode 0, LSB first: 0xAA out, miso 1,0,1,1,0,0,1,0 in.
        load(8'hAA);
        miso_pat = 8'b0100_1101;
        mosi_exp = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            strobe(1'b1, 1'b0, 1'b1, 1'b0, miso_pat[i]);
            check_eq($sformatf("m0_mosi_%0d", i), {31'd0, bus.mosi},
                     {31'd0, mosi_exp[i]});
            if (i == 1) begin
`ifdef SPI_LOOPBACK_EN
                check_eq("m0_lag", {24'd0, bus.data_miso}, 32'h00);
`else
                check_eq("m0_lag", {24'd0, bus.data_miso}, 32'h01);
`endif
            end
        end
        tick();
`ifdef SPI_LOOPBACK_EN
        check_eq("m0_data_miso", {24'd0, bus.data_miso}, 32'hAA);
`else
        check_eq("m0_data_miso", {24'd0, bus.data_miso}, 32'h4D);
`endif

        // Mode 3 MSB first: 0xC3 on flag_low; flag_high ignored.
        bus.cpha = 1'b1; bus.cpol = 1'b1; bus.lsbfe = 1'b0;
        load(8'hC3);
        mosi_exp = 8'hC3;
        exp_mosi = 1'b1;
        for (int i = 0; i < 8; i++) begin
            strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            check_eq($sformatf("m3_ignored_%0d", i), {31'd0, bus.mosi},
                     {31'd0, exp_mosi});
            exp_mosi = mosi_exp[7-i];
            strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check_eq($sformatf("m3_mosi_%0d", i), {31'd0, bus.mosi},
                     {31'd0, exp_mosi});
        end

        // Mode 1: only flag_high/flags_high shift; 0x69 MSB first, miso=1.
        bus.cpha = 1'b1; bus.cpol = 1'b0;
        load(8'h69);
        strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("m1_low_ignored_mosi", {31'd0, bus.mosi}, 32'd1);
        tick();
`ifdef SPI_LOOPBACK_EN
        check_eq("m1_low_ignored_rx", {24'd0, bus.data_miso}, 32'hAA);
`else
        check_eq("m1_low_ignored_rx", {24'd0, bus.data_miso}, 32'h4D);
`endif
        mosi_exp = 8'h69;
        for (int i = 0; i < 8; i++) begin
            strobe(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            check_eq($sformatf("m1_mosi_%0d", i), {31'd0, bus.mosi},
                     {31'd0, mosi_exp[7-i]});
        end
        tick();
`ifdef SPI_LOOPBACK_EN
        check_eq("m1_data_miso", {24'd0, bus.data_miso}, 32'h69);
`else
        check_eq("m1_data_miso", {24'd0, bus.data_miso}, 32'hFF);
`endif

        // ss abort after 3 strobes, then reload 0x0F LSB first.
        bus.cpha = 1'b0; bus.cpol = 1'b0; bus.lsbfe = 1'b1;
        load(8'hF0);
        for (int i = 0; i < 3; i++) begin
            strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            check_eq($sformatf("ss_pre_mosi_%0d", i), {31'd0, bus.mosi}, 32'd0);
        end
        bus.ss = 1'b1;
        strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("ss_high_hold_mosi", {31'd0, bus.mosi}, 32'd0);
        bus.ss = 1'b0;
        load(8'h0F);
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("ss_restart_bit0", {31'd0, bus.mosi}, 32'd1);
        // RX counter must restart at bit 0 as well.
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
`ifdef SPI_LOOPBACK_EN
        check_eq("ss_rx_restart", {24'd0, bus.data_miso}, 32'h69);
`else
        check_eq("ss_rx_restart", {24'd0, bus.data_miso}, 32'hF8);
`endif
        mosi_exp = 8'h0F;
        for (int i = 1; i < 5; i++) begin
            strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check_eq($sformatf("ss_post_mosi_%0d", i), {31'd0, bus.mosi},
                     {31'd0, mosi_exp[i]});
        end

        // Reset mid-frame discards the frame.
        load(8'hFF);
        strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("midframe_mosi", {31'd0, bus.mosi}, 32'd1);
        PRESET = 1'b1;
        strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        PRESET = 1'b0;
        check_eq("midreset_mosi", {31'd0, bus.mosi}, 32'd0);
        check_eq("midreset_data_miso", {24'd0, bus.data_miso}, 32'h00);
        tick();
        check_eq("midreset_rx_clear", {24'd0, bus.data_miso}, 32'h00);
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("midreset_tx_clear", {31'd0, bus.mosi}, 32'd0);

`ifdef SPI_LOOPBACK_EN
        // Loopback: a full frame returns the transmitted byte.
        load(8'h5A);
        for (int i = 0; i < 8; i++) begin
            strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        tick();
        check_eq("loopback_data_miso", {24'd0, bus.data_miso}, 32'h5A);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_shift_register.md
Name: spi_shift_register

Overview:
- Datapath shift register of the SPI master.
- Loads a parallel transmit byte and serialises it onto mosi on SCLK-edge strobes from the baud generator.
- Samples miso on its receive strobes and presents the assembled byte in parallel on data_miso.
- Sits between the SPI control FSM (ss, send_data, receive_data) and the baud-rate generator (flag/flags strobes).

Parameters:
- DATA_WIDTH, 8: bits per SPI frame. Counters are clog2(DATA_WIDTH) bits wide.

Ports:
- PCLK  input  1  system clock; all logic on rising edge.
- PRESET  input  1  synchronous, active-high reset.
- ss  input  1  slave select, active low. While high, shifting is disabled and bit counters are held at 0.
- send_data  input  1  one-cycle pulse: load data_mosi into the transmit register.
- lsbfe  input  1  1 = LSB first, 0 = MSB first; applies to both TX and RX.
- cpha  input  1  clock phase.
- cpol  input  1  clock polarity.
- flag_low  input  1  TX strobe, one PCLK wide, for modes with cpha^cpol = 0.
- flag_high  input  1  TX strobe for modes with cpha^cpol = 1.
- flags_low  input  1  RX sample strobe for modes with cpha^cpol = 0.
- flags_high  input  1  RX sample strobe for modes with cpha^cpol = 1.
- data_mosi  input  DATA_WIDTH  parallel transmit byte.
- miso  input  1  serial receive input.
- receive_data  input  1  level: while high, data_miso tracks the receive register.
- mosi  output  1  registered serial transmit output.
- data_miso  output  DATA_WIDTH  registered parallel receive output.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (PRESET=1 at PCLK edge): mosi=0, data_miso=0, tx_reg=0, rx_reg=0, tx_cnt=0, rx_cnt=0. Reset overrides everything, including mid-frame; the partial frame is discarded.
- Strobe select: sel = cpha ^ cpol.
  - sel=0: tx_strobe = flag_low, rx_strobe = flags_low.
  - sel=1: tx_strobe = flag_high, rx_strobe = flags_high.
  - Non-selected strobes are ignored.
- Load: send_data=1 sets tx_reg <= data_mosi and tx_cnt <= 0 on the same edge. Load works regardless of ss. Load has priority over a coincident tx_strobe, which is ignored.
- Transmit, when ss=0 and tx_strobe=1:
  - mosi <= tx_reg[idx], where idx = tx_cnt if lsbfe=1, else DATA_WIDTH-1-tx_cnt.
  - tx_cnt increments and wraps DATA_WIDTH-1 -> 0.
  - Latency: mosi changes on the PCLK edge where the strobe is sampled.
- Receive, when ss=0 and rx_strobe=1:
  - rx_reg[idx] <= miso, with idx computed as for TX using rx_cnt.
  - rx_cnt increments and wraps at DATA_WIDTH.
  - Other rx_reg bits hold.
- Output: when receive_data=1, data_miso <= rx_reg each cycle (one-cycle lag behind rx_reg). When receive_data=0, data_miso holds.
- ss=1: tx_cnt and rx_cnt forced to 0; mosi, tx_reg and rx_reg hold; strobes ignored.
- Coincident tx_strobe and rx_strobe on the same edge: both actions occur independently.
- Changing lsbfe, cpha or cpol mid-frame takes effect on the next strobe; no error is flagged.
- No handshakes beyond the above; strobes are trusted to be single-cycle pulses.

Optional Feature:
- SPI_LOOPBACK_EN defined:
  - The receive path samples the internal mosi register instead of the miso pin; miso is unused.
  - After a full frame with matching lsbfe, rx_reg equals the transmitted byte.
- Not defined: the receive path samples the miso pin as specified above.

Test Plan:
- Reset: PRESET=1 for 1 cycle with strobes toggling -> mosi=0, data_miso=0x00. After release, outputs hold 0 until a strobe.
- Mode 0, LSB first:
  - Stimulus: data_mosi=0xAA, send_data pulse, ss=0, receive_data=1, 8 coincident flag_low/flags_low pulses, with miso = 1,0,1,1,0,0,1,0 per strobe.
  - mosi sequence 0,1,0,1,0,1,0,1.
  - data_miso=0x4D one cycle after the last strobe.
- MSB first, mode 3 (cpha=1, cpol=1 -> sel=0): data_mosi=0xC3, lsbfe=0, 8 flag_low pulses -> mosi sequence 1,1,0,0,0,0,1,1. Any flag_high pulses are ignored.
- Mode 1 (cpha=1, cpol=0): only flag_high/flags_high shift. flag_low pulses leave mosi and counters unchanged. miso=1 on all 8 flags_high pulses -> data_miso=0xFF.
- ss=1 after 3 strobes, then ss=0 and a new send_data of 0x0F with lsbfe=1 -> next strobe drives bit0 (mosi=1); counters restart from 0.
- With SPI_LOOPBACK_EN, data_mosi=0x5A, 8 coincident TX/RX strobes (sel=0) -> data_miso=0x5A.
